// File: rtl/vdp_cpu_vram_port_if.sv
// Toggle-handshake bus between the CPU VRAM port and the VRAM arbiter.
// master = CPU port side (issues requests), slave = arbiter side.
interface vdp_cpu_vram_port_if;
  logic [1:0]  DOTSTATE;
  logic [7:0]  PRAMDAT;
  logic        VDPVRAMWRACK;
  logic        VDPVRAMRDACK;
  logic        VDPVRAMADDRSETACK;
  logic        VDPVRAMREADINGR;
  logic [7:0]  VDPVRAMACCESSDATA;
  logic [16:0] VDPVRAMACCESSADDRTMP;
  logic        VDPVRAMWRREQ;
  logic        VDPVRAMRDREQ;
  logic        VDPVRAMADDRSETREQ;
  logic        VDPVRAMREADINGA;

  modport master (
    input  DOTSTATE, PRAMDAT, VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR,
    output VDPVRAMACCESSDATA, VDPVRAMACCESSADDRTMP, VDPVRAMWRREQ, VDPVRAMRDREQ,
           VDPVRAMADDRSETREQ, VDPVRAMREADINGA
  );

  modport slave (
    output DOTSTATE, PRAMDAT, VDPVRAMWRACK, VDPVRAMRDACK, VDPVRAMADDRSETACK, VDPVRAMREADINGR,
    input  VDPVRAMACCESSDATA, VDPVRAMACCESSADDRTMP, VDPVRAMWRREQ, VDPVRAMRDREQ,
           VDPVRAMADDRSETREQ, VDPVRAMREADINGA
  );
endinterface

// File: rtl/vdp_cpu_vram_port.sv
// CPU #98/#99 front end of the VRAM arbiter: toggles appear one cycle after cpu_req.
// No backpressure on #99; #98 accesses made while cpu_wait is high are dropped.
module vdp_cpu_vram_port (
  input  logic                       CLK21M,
  input  logic                       RESET,
  input  logic                       cpu_req,
  input  logic                       cpu_wr,
  input  logic                       cpu_port,
  input  logic [7:0]                 cpu_dbi,
  input  logic                       status_rd,
  input  logic [2:0]                 reg_r14,
  output logic [7:0]                 cpu_dbo,
  output logic                       cpu_wait,
  output logic                       reg_wr,
  output logic [5:0]                 reg_num,
  output logic [7:0]                 reg_data,
  vdp_cpu_vram_port_if.master        vram
);

  typedef enum logic {ADDR_LO, ADDR_HI} ctl_state_t;

  ctl_state_t state, state_nxt;
  logic [7:0] latch_lo;
  logic       latch_en, addr_set, rd_setup, reg_set;
  logic       dp_wr, dp_rd, capture;

  assign cpu_wait = (vram.VDPVRAMWRREQ      != vram.VDPVRAMWRACK) |
                    (vram.VDPVRAMRDREQ      != vram.VDPVRAMRDACK) |
                    (vram.VDPVRAMADDRSETREQ != vram.VDPVRAMADDRSETACK);

  assign dp_wr   = cpu_req & ~cpu_port &  cpu_wr & ~cpu_wait;
  assign dp_rd   = cpu_req & ~cpu_port & ~cpu_wr & ~cpu_wait;
  assign capture = (vram.DOTSTATE == 2'b01) & (vram.VDPVRAMREADINGR != vram.VDPVRAMREADINGA);

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) state <= ADDR_LO;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    addr_set  = 1'b0;
    rd_setup  = 1'b0;
    reg_set   = 1'b0;
    if (cpu_req && cpu_port && cpu_wr) begin
      if (state == ADDR_LO) begin
        latch_en  = 1'b1;
        state_nxt = ADDR_HI;
      end else begin
        state_nxt = ADDR_LO;
        case (cpu_dbi[7:6])
          2'b00: begin addr_set = 1'b1; rd_setup = 1'b1; end
          2'b01: addr_set = 1'b1;
          2'b10: reg_set  = 1'b1;
          default: ;
        endcase
      end
    end
    // Status read or any data-port access resynchronises the byte pairing,
    // after a coincident #99 write has been acted on.
    if (status_rd || (cpu_req && !cpu_port)) state_nxt = ADDR_LO;
  end

  always_ff @(posedge CLK21M or posedge RESET) begin
    if (RESET) begin
      latch_lo                  <= 8'h00;
      cpu_dbo                   <= 8'h00;
      reg_wr                    <= 1'b0;
      reg_num                   <= 6'd0;
      reg_data                  <= 8'h00;
      vram.VDPVRAMACCESSDATA    <= 8'h00;
      vram.VDPVRAMACCESSADDRTMP <= 17'd0;
      vram.VDPVRAMWRREQ         <= 1'b0;
      vram.VDPVRAMRDREQ         <= 1'b0;
      vram.VDPVRAMADDRSETREQ    <= 1'b0;
      vram.VDPVRAMREADINGA      <= 1'b0;
    end else begin
      reg_wr <= reg_set;
      if (latch_en) latch_lo <= cpu_dbi;
      if (addr_set) begin
        vram.VDPVRAMACCESSADDRTMP <= {reg_r14, cpu_dbi[5:0], latch_lo};
        vram.VDPVRAMADDRSETREQ    <= ~vram.VDPVRAMADDRSETREQ;
      end
      if (rd_setup || dp_rd) vram.VDPVRAMRDREQ <= ~vram.VDPVRAMRDREQ;
      if (reg_set) begin
        reg_num  <= cpu_dbi[5:0];
        reg_data <= latch_lo;
      end
      if (dp_wr) begin
        vram.VDPVRAMACCESSDATA <= cpu_dbi;
        vram.VDPVRAMWRREQ      <= ~vram.VDPVRAMWRREQ;
      end
      // Fresh VRAM data wins over the write mirror when both land together.
      if (capture) begin
        cpu_dbo              <= vram.PRAMDAT;
        vram.VDPVRAMREADINGA <= vram.VDPVRAMREADINGR;
      end else if (dp_wr) begin
        cpu_dbo <= cpu_dbi;
      end
    end
  end

endmodule

// File: tb/tb_vdp_cpu_vram_port.sv
// Bench for vdp_cpu_vram_port: directed scenarios with literal expectations,
// then randomized CPU/arbiter traffic compared every cycle against a behavioural model.
module tb_vdp_cpu_vram_port;

  logic       CLK21M;
  logic       RESET;
  logic       cpu_req, cpu_wr, cpu_port, status_rd;
  logic [7:0] cpu_dbi;
  logic [2:0] reg_r14;
  logic [7:0] cpu_dbo;
  logic       cpu_wait, reg_wr;
  logic [5:0] reg_num;
  logic [7:0] reg_data;

  vdp_cpu_vram_port_if vif();

  vdp_cpu_vram_port dut (
    .CLK21M    (CLK21M),
    .RESET     (RESET),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_port  (cpu_port),
    .cpu_dbi   (cpu_dbi),
    .status_rd (status_rd),
    .reg_r14   (reg_r14),
    .cpu_dbo   (cpu_dbo),
    .cpu_wait  (cpu_wait),
    .reg_wr    (reg_wr),
    .reg_num   (reg_num),
    .reg_data  (reg_data),
    .vram      (vif)
  );

  initial CLK21M = 1'b0;
  always #5 CLK21M = ~CLK21M;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  bit arb_auto = 0;

  // Behavioural model state
  bit         m_hi;
  logic [7:0] m_lo, m_dbo, m_data, m_rdat;
  logic [16:0] m_addr;
  logic [5:0] m_rnum;
  bit         m_wrreq, m_rdreq, m_asreq, m_rdga, m_regwr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_wait();
    return (m_wrreq != vif.VDPVRAMWRACK) || (m_rdreq != vif.VDPVRAMRDACK) ||
           (m_asreq != vif.VDPVRAMADDRSETACK);
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_dbo = 0; m_data = 0; m_rdat = 0; m_addr = 0; m_rnum = 0;
    m_wrreq = 0; m_rdreq = 0; m_asreq = 0; m_rdga = 0; m_regwr = 0;
  endtask

  task automatic model_step();
    bit pend;
    logic [7:0] nd;
    pend = exp_wait();
    nd = m_dbo;
    m_regwr = 0;
    if (cpu_req && cpu_port && cpu_wr) begin
      if (!m_hi) begin
        m_lo = cpu_dbi;
        m_hi = 1;
      end else begin
        m_hi = 0;
        if (cpu_dbi < 8'h80) begin
          m_addr  = 17'(int'(reg_r14) * 16384 + int'(cpu_dbi % 64) * 256 + int'(m_lo));
          m_asreq = !m_asreq;
          if (cpu_dbi < 8'h40) m_rdreq = !m_rdreq;
        end else if (cpu_dbi < 8'hC0) begin
          m_rnum  = 6'(cpu_dbi - 8'h80);
          m_rdat  = m_lo;
          m_regwr = 1;
        end
      end
    end
    if (status_rd || (cpu_req && !cpu_port)) m_hi = 0;
    if (cpu_req && !cpu_port && !pend) begin
      if (cpu_wr) begin
        m_data  = cpu_dbi;
        nd      = cpu_dbi;
        m_wrreq = !m_wrreq;
      end else begin
        m_rdreq = !m_rdreq;
      end
    end
    if (vif.DOTSTATE == 2'd1 && vif.VDPVRAMREADINGR != m_rdga) begin
      nd     = vif.PRAMDAT;
      m_rdga = vif.VDPVRAMREADINGR;
    end
    m_dbo = nd;
  endtask

  // Arbiter stand-in: random ack latency; serving a read also flags new read data.
  task automatic arb_step();
    if (vif.VDPVRAMWRACK != m_wrreq && $urandom_range(0, 2) == 0) vif.VDPVRAMWRACK = m_wrreq;
    if (vif.VDPVRAMADDRSETACK != m_asreq && $urandom_range(0, 2) == 0) vif.VDPVRAMADDRSETACK = m_asreq;
    if (vif.VDPVRAMRDACK != m_rdreq && $urandom_range(0, 2) == 0) begin
      vif.VDPVRAMRDACK    = m_rdreq;
      vif.VDPVRAMREADINGR = ~vif.VDPVRAMREADINGR;
    end
    vif.DOTSTATE = 2'($urandom_range(0, 3));
    vif.PRAMDAT  = 8'($urandom);
  endtask

  task automatic arb_reset();
    vif.VDPVRAMWRACK = 0; vif.VDPVRAMRDACK = 0; vif.VDPVRAMADDRSETACK = 0;
    vif.VDPVRAMREADINGR = 0; vif.DOTSTATE = 0; vif.PRAMDAT = 0;
  endtask

  task automatic tick();
    @(posedge CLK21M);
    #1;
    if (RESET) model_reset();
    else       model_step();
    if (arb_auto) arb_step();
  endtask

  task automatic cpu_acc(input bit port, input bit wr, input logic [7:0] d);
    cpu_req = 1; cpu_port = port; cpu_wr = wr; cpu_dbi = d;
    tick();
    cpu_req = 0;
  endtask

  task automatic ack_all();
    vif.VDPVRAMWRACK      = m_wrreq;
    vif.VDPVRAMRDACK      = m_rdreq;
    vif.VDPVRAMADDRSETACK = m_asreq;
    tick();
  endtask

  always @(negedge CLK21M) begin
    if (chk_en) begin
      check("cpu_dbo",  cpu_dbo,  m_dbo);
      check("cpu_wait", cpu_wait, exp_wait());
      check("wrreq",    vif.VDPVRAMWRREQ, m_wrreq);
      check("rdreq",    vif.VDPVRAMRDREQ, m_rdreq);
      check("asreq",    vif.VDPVRAMADDRSETREQ, m_asreq);
      check("readinga", vif.VDPVRAMREADINGA, m_rdga);
      check("acc_data", vif.VDPVRAMACCESSDATA, m_data);
      check("acc_addr", vif.VDPVRAMACCESSADDRTMP, m_addr);
      check("reg_wr",   reg_wr,   m_regwr);
      check("reg_num",  reg_num,  m_rnum);
      check("reg_data", reg_data, m_rdat);
    end
  end

  initial begin
    RESET = 1; cpu_req = 0; cpu_wr = 0; cpu_port = 0; cpu_dbi = 0; status_rd = 0; reg_r14 = 0;
    arb_reset();
    model_reset();
    repeat (2) tick();
    chk_en = 1;
    check("rst_dbo", cpu_dbo, 8'h00);
    check("rst_wait", cpu_wait, 1'b0);
    check("rst_addr", vif.VDPVRAMACCESSADDRTMP, 17'h0);
    check("rst_toggles", {vif.VDPVRAMWRREQ, vif.VDPVRAMRDREQ, vif.VDPVRAMADDRSETREQ, vif.VDPVRAMREADINGA}, 4'h0);
    RESET = 0;
    tick();

    // 1: write-setup address
    reg_r14 = 3'b001;
    cpu_acc(1, 1, 8'h34);
    cpu_acc(1, 1, 8'h52);
    check("t1_addr", vif.VDPVRAMACCESSADDRTMP, 17'h05234);
    check("t1_model_addr", m_addr, 17'h05234);
    check("t1_as", vif.VDPVRAMADDRSETREQ, 1'b1);
    check("t1_wr_rd", {vif.VDPVRAMWRREQ, vif.VDPVRAMRDREQ}, 2'b00);
    check("t1_wait", cpu_wait, 1'b1);
    ack_all();

    // 2: read setup, capture, data-port read
    reg_r14 = 3'b000;
    cpu_acc(1, 1, 8'h00);
    cpu_acc(1, 1, 8'h10);
    check("t2_addr", vif.VDPVRAMACCESSADDRTMP, 17'h01000);
    check("t2_as_rd", {vif.VDPVRAMADDRSETREQ, vif.VDPVRAMRDREQ}, 2'b01);
    ack_all();
    vif.VDPVRAMREADINGR = 1; vif.DOTSTATE = 2'b01; vif.PRAMDAT = 8'hA5;
    tick();
    vif.DOTSTATE = 2'b00; vif.PRAMDAT = 8'h3C;
    check("t2_capture", cpu_dbo, 8'hA5);
    check("t2_readinga", vif.VDPVRAMREADINGA, 1'b1);
    cpu_req = 1; cpu_port = 0; cpu_wr = 0;
    #1;
    check("t2_rd_dbo", cpu_dbo, 8'hA5);
    tick();
    cpu_req = 0;
    check("t2_rdreq", vif.VDPVRAMRDREQ, 1'b0);
    check("t2_rd_wait", cpu_wait, 1'b1);
    ack_all();

    // 3: data-port write, dropped write while waiting
    cpu_acc(0, 1, 8'h77);
    check("t3_data", vif.VDPVRAMACCESSDATA, 8'h77);
    check("t3_dbo", cpu_dbo, 8'h77);
    check("t3_wrreq", vif.VDPVRAMWRREQ, 1'b1);
    cpu_acc(0, 1, 8'h11);
    check("t3_drop_wrreq", vif.VDPVRAMWRREQ, 1'b1);
    check("t3_drop_data", vif.VDPVRAMACCESSDATA, 8'h77);
    tick();
    check("t3_wait", cpu_wait, 1'b1);
    vif.VDPVRAMWRACK = 1;
    #1;
    check("t3_wait_clr", cpu_wait, 1'b0);
    tick();

    // 4: register write
    cpu_acc(1, 1, 8'hFF);
    cpu_acc(1, 1, 8'h87);
    check("t4_reg_wr", reg_wr, 1'b1);
    check("t4_reg_num", reg_num, 6'd7);
    check("t4_reg_data", reg_data, 8'hFF);
    check("t4_toggles", {vif.VDPVRAMWRREQ, vif.VDPVRAMRDREQ, vif.VDPVRAMADDRSETREQ}, 3'b100);
    tick();
    check("t4_reg_wr_pulse", reg_wr, 1'b0);

    // 5: status read resynchronises pairing
    cpu_acc(1, 1, 8'h12);
    status_rd = 1;
    tick();
    status_rd = 0;
    cpu_acc(1, 1, 8'h40);
    check("t5_no_as", vif.VDPVRAMADDRSETREQ, 1'b0);
    cpu_acc(1, 1, 8'h41);
    check("t5_addr", vif.VDPVRAMACCESSADDRTMP, 17'h00140);
    check("t5_as", vif.VDPVRAMADDRSETREQ, 1'b1);
    ack_all();

    // 6: reset mid-operation
    cpu_acc(0, 1, 8'h5A);
    cpu_acc(1, 1, 8'h99);
    check("t6_pending", cpu_wait, 1'b1);
    RESET = 1;
    model_reset();
    arb_reset();
    #1;
    check("t6_toggles", {vif.VDPVRAMWRREQ, vif.VDPVRAMRDREQ, vif.VDPVRAMADDRSETREQ, vif.VDPVRAMREADINGA}, 4'h0);
    check("t6_wait", cpu_wait, 1'b0);
    check("t6_dbo", cpu_dbo, 8'h00);
    tick();
    RESET = 0;
    reg_r14 = 3'b010;
    cpu_acc(1, 1, 8'h21);
    cpu_acc(1, 1, 8'h43);
    check("t6_addr", vif.VDPVRAMACCESSADDRTMP, 17'h08321);
    ack_all();

    // Randomized traffic
    arb_auto = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        RESET = 1;
        model_reset();
        arb_reset();
        tick();
        RESET = 0;
      end
      cpu_req   = ($urandom_range(0, 7) < 3);
      cpu_port  = 1'($urandom);
      cpu_wr    = 1'($urandom);
      cpu_dbi   = 8'($urandom);
      status_rd = ($urandom_range(0, 9) == 0);
      reg_r14   = 3'($urandom);
      tick();
    end
    cpu_req = 0; status_rd = 0;
    tick();
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vdp_cpu_vram_port.md
Name: vdp_cpu_vram_port

Overview:
- CPU-facing front end of the VRAM arbiter. Decodes Z80 I/O accesses to data port (#98) and control port (#99).
- Assembles the two-byte address/register sequence and issues toggle-handshake VRAM write, read and address-set requests to the arbiter.
- Keeps a one-byte read-ahead buffer for CPU VRAM reads.

Parameters:
- none

Ports:
- CLK21M  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- DOTSTATE  in  2  dot phase; VRAM read data valid when 2'b01
- cpu_req  in  1  one-cycle strobe, CPU I/O access this cycle
- cpu_wr  in  1  1 = write, 0 = read (qualified by cpu_req)
- cpu_port  in  1  0 = data port #98, 1 = control port #99
- cpu_dbi  in  8  CPU write data
- status_rd  in  1  one-cycle strobe, status register read on #99 (read handled elsewhere)
- reg_r14  in  3  VRAM address bits A16:A14
- PRAMDAT  in  8  VRAM read data bus
- VDPVRAMWRACK  in  1  arbiter write ack (toggle)
- VDPVRAMRDACK  in  1  arbiter read ack (toggle)
- VDPVRAMADDRSETACK  in  1  arbiter address-set ack (toggle)
- VDPVRAMREADINGR  in  1  arbiter read-issued toggle
- cpu_dbo  out  8  read-ahead buffer contents
- cpu_wait  out  1  a VRAM request is outstanding
- VDPVRAMACCESSDATA  out  8  byte to write
- VDPVRAMACCESSADDRTMP  out  17  new VRAM address
- VDPVRAMWRREQ  out  1  write request (toggle)
- VDPVRAMRDREQ  out  1  read request (toggle)
- VDPVRAMADDRSETREQ  out  1  address-set request (toggle)
- VDPVRAMREADINGA  out  1  read-data-captured toggle
- reg_wr  out  1  one-cycle register write strobe
- reg_num  out  6  register index
- reg_data  out  8  register value

Behaviour:
- Reset values:
  - all outputs 0; addr_tmp = 0; cpu_dbo = 8'h00.
  - internal second_byte flag = 0; latch_lo = 0.
- Request is pending when REQ != ACK, separately for WR, RD and ADDRSET.
- cpu_wait = WR pending | RD pending | ADDRSET pending, combinational from the current flops. The CPU must not issue #98 accesses while cpu_wait = 1; if it does, the access is dropped and no toggle occurs.
- Control-port write FSM (two states, ADDR_LO / ADDR_HI):
  - ADDR_LO, #99 write: latch_lo <= cpu_dbi; go to ADDR_HI.
  - ADDR_HI, #99 write: return to ADDR_LO; action depends on cpu_dbi[7:6]:
    - 00 (read setup): VDPVRAMACCESSADDRTMP <= {reg_r14, cpu_dbi[5:0], latch_lo}; toggle ADDRSETREQ and RDREQ in the same cycle, so the arbiter loads the address and prefetches.
    - 01 (write setup): same address load and ADDRSET toggle; no RDREQ toggle.
    - 10 (register write): reg_num <= cpu_dbi[5:0]; reg_data <= latch_lo; reg_wr = 1 for exactly one cycle.
    - 11: ignored, no action, state still returns to ADDR_LO.
  - status_rd, or any #98 access (read or write), forces the FSM to ADDR_LO. latch_lo is not modified.
  - status_rd coincident with a #99 write: the write is processed first and the state then ends in ADDR_LO.
- Data-port write: VDPVRAMACCESSDATA <= cpu_dbi; cpu_dbo <= cpu_dbi (buffer mirrors last write); toggle WRREQ.
- Data-port read: cpu_dbo is valid combinationally in the request cycle; then toggle RDREQ to prefetch the next byte. The arbiter auto-increments the address; this block does not.
- Read capture: when DOTSTATE == 2'b01 and VDPVRAMREADINGR != VDPVRAMREADINGA, then cpu_dbo <= PRAMDAT and VDPVRAMREADINGA <= VDPVRAMREADINGR. Capture has priority over a simultaneous data-port write update of cpu_dbo.
- Latency: a request toggle is visible on the cycle after the cpu_req edge. Each handshake toggles at most once per pending cycle.
- Reset mid-operation clears every toggle to 0. Arbiter ACKs are reset to 0 by the same RESET, so no stale request survives.

Test Plan:
1. Reset, then #99 writes 8'h34 then 8'h52 with reg_r14 = 3'b001 -> ADDRTMP = 17'h05234; ADDRSETREQ toggles; WRREQ and RDREQ unchanged; FSM back in ADDR_LO.
2. Read setup #99 8'h00 then 8'h10 with reg_r14 = 0 -> ADDRSETREQ and RDREQ both toggle. Set READINGR != READINGA and PRAMDAT = 8'hA5 at DOTSTATE 01 -> cpu_dbo = 8'hA5 and READINGA follows. A #98 read then returns 8'hA5 and toggles RDREQ.
3. #98 write 8'h77 -> ACCESSDATA = 8'h77, cpu_dbo = 8'h77, WRREQ toggles, cpu_wait = 1 until WRACK matches. A second #98 write while waiting -> no toggle.
4. #99 8'hFF then 8'h87 -> reg_wr pulses one cycle with reg_num = 7, reg_data = 8'hFF; no VRAM toggles.
5. #99 8'h12, then status_rd, then #99 8'h40 -> treated as a new low byte: latch_lo = 8'h40, FSM in ADDR_HI, no ADDRSET toggle.
6. Assert RESET with WRREQ pending and the FSM in ADDR_HI -> all toggles 0, cpu_wait = 0, FSM in ADDR_LO, cpu_dbo = 8'h00.
